mult_arbiter: RTL and testbench

Two-requester round-robin controller for the shared sequential signed-multiplier datapath. It arbitrates between two independent operand sources, latches the winner's operands, and sequences the datapath through load, conditional accumulate and shift. It terminates on the datapath zero flag or an iteration bound, then returns the sign-magnitude product to the granted requester with a one-cycle done pulse. It sits between the push-button and operand-source logic and the datapath, and replaces the single-user control unit in the top level.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_arbiter_if.sv | 30 +++
 rtl/rr_arbiter2.sv | 27 ++
 rtl/mult_arbiter.sv | 129 ++++++++++++
 tb/tb_mult_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed-multiplier control path and
// its datapath: default widths, FSM state encoding and product-mux selects.
package mult_pkg;

  localparam int OP_W_DEF     = 8;
  localparam int PROD_W_DEF   = 14;
  localparam int ITER_MAX_DEF = OP_W_DEF;

  // Product register input mux: clear to zero, or take the adder sum.
  localparam logic PSEL_ZERO = 1'b0;
  localparam logic PSEL_SUM  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACC,
    ST_SHIFT,
    ST_CAPTURE
  } state_e;

endpackage

// File: rtl/mult_arbiter_if.sv
// Control/status bundle between the multiplier controller and the shared
// shift-add datapath.
//   master (controller): drives latched operands and load/reg_en/psel/shift_en,
//                        observes zflag, lsb_multiplier, product, sign.
//   slave  (datapath)  : the mirror image.
interface mult_arbiter_if import mult_pkg::*; #(
  parameter int OP_W   = OP_W_DEF,
  parameter int PROD_W = PROD_W_DEF
);
  logic [OP_W-1:0]   dp_multiplier;
  logic [OP_W-1:0]   dp_multiplicand;
  logic              load;
  logic              reg_en;
  logic              psel;
  logic              shift_en;
  logic              zflag;
  logic              lsb_multiplier;
  logic [PROD_W-1:0] product;
  logic              sign;

  modport master (
    output dp_multiplier, dp_multiplicand, load, reg_en, psel, shift_en,
    input  zflag, lsb_multiplier, product, sign
  );

  modport slave (
    input  dp_multiplier, dp_multiplicand, load, reg_en, psel, shift_en,
    output zflag, lsb_multiplier, product, sign
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker.
//   clk, rst   : clock, synchronous active-low reset
//   req[1:0]   : live requests
//   adv        : strobe at end of service; pointer moves away from served_idx
//   served_idx : index of the requester just served
//   pick[1:0]  : one-hot winner (zero when no request), combinational
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       served_idx,
  output logic [1:0] pick
);
  // ptr_q = index that wins a tie; reset favours requester 0.
  logic ptr_q;

  always_ff @(posedge clk) begin
    if (!rst)     ptr_q <= 1'b0;
    else if (adv) ptr_q <= ~served_idx;
  end

  always_comb begin
    pick = req;
    if (req == 2'b11) pick = ptr_q ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/mult_arbiter.sv
// Two-requester round-robin controller for the shared sequential signed
// multiplier. Grants one requester, latches its operands, steps the datapath
// through load / conditional accumulate / shift until zflag or the iteration
// bound, then returns the sign-magnitude product with a one-cycle done pulse.
//   sys_clk, rst            : clock, synchronous active-low reset
//   req0/1, mplr0/1, mcnd0/1: requester level requests and operands
//   gnt0/1, done0/1, busy   : grant (LOAD..CAPTURE), done pulse, not-idle
//   product_out, sign_out   : registered result, held until next CAPTURE
//   dp                      : datapath control/status bundle (master side)
module mult_arbiter import mult_pkg::*; #(
  parameter int OP_W     = OP_W_DEF,
  parameter int PROD_W   = PROD_W_DEF,
  parameter int ITER_MAX = OP_W
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [OP_W-1:0]   mplr0,
  input  logic [OP_W-1:0]   mplr1,
  input  logic [OP_W-1:0]   mcnd0,
  input  logic [OP_W-1:0]   mcnd1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              busy,
  output logic [PROD_W-1:0] product_out,
  output logic              sign_out,
  mult_arbiter_if.master    dp
);
  localparam int CNT_W = $clog2(ITER_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       gnt_q;
  logic [1:0]       pick;
  logic             acc_done;

  rr_arbiter2 u_rr (
    .clk        (sys_clk),
    .rst        (rst),
    .req        ({req1, req0}),
    .adv        (state_q == ST_CAPTURE),
    .served_idx (gnt_q[1]),
    .pick       (pick)
  );

  // Bound and zflag can coincide (|mplr| = 2^(OP_W-1)); either ends the loop.
  assign acc_done = dp.zflag || (cnt_q == CNT_W'(ITER_MAX));

  // State register
  always_ff @(posedge sys_clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req0 || req1) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_ACC;
      ST_ACC:     state_d = acc_done ? ST_CAPTURE : ST_SHIFT;
      ST_SHIFT:   state_d = ST_ACC;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    dp.load     = 1'b0;
    dp.reg_en   = 1'b0;
    dp.psel     = PSEL_ZERO;
    dp.shift_en = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;
    case (state_q)
      ST_LOAD: begin
        dp.load   = 1'b1;
        dp.reg_en = 1'b1;
      end
      ST_ACC: if (!acc_done) begin
        dp.reg_en = dp.lsb_multiplier;
        dp.psel   = PSEL_SUM;
      end
      ST_SHIFT:   dp.shift_en = 1'b1;
      ST_CAPTURE: begin
        done0 = gnt_q[0];
        done1 = gnt_q[1];
      end
      default: ;
    endcase
  end

  assign gnt0 = gnt_q[0];
  assign gnt1 = gnt_q[1];
  assign busy = (state_q != ST_IDLE);

  // Grant, operand latch, iteration count and result capture
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      gnt_q              <= '0;
      cnt_q              <= '0;
      dp.dp_multiplier   <= '0;
      dp.dp_multiplicand <= '0;
      product_out        <= '0;
      sign_out           <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req0 || req1) begin
          // Operands are taken only here; requesters may change them later.
          gnt_q              <= pick;
          dp.dp_multiplier   <= pick[1] ? mplr1 : mplr0;
          dp.dp_multiplicand <= pick[1] ? mcnd1 : mcnd0;
        end
        ST_LOAD:  cnt_q <= '0;
        ST_ACC: if (acc_done) begin
          product_out <= dp.product;
          sign_out    <= dp.sign;
        end
        ST_SHIFT:   cnt_q <= cnt_q + CNT_W'(1);
        ST_CAPTURE: gnt_q <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
  import mult_pkg::*;

  localparam int OP_W   = 8;
  localparam int PROD_W = 14;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [OP_W-1:0]   mplr0 = '0, mplr1 = '0, mcnd0 = '0, mcnd1 = '0;
  logic              gnt0, gnt1, done0, done1, busy, sign_out;
  logic [PROD_W-1:0] product_out;

  int n_chk = 0;
  int n_fail = 0;
  int mdl_last = 1;   // index served last; 1 means requester 0 wins a tie

  mult_arbiter_if #(.OP_W(OP_W), .PROD_W(PROD_W)) dpi ();

  mult_arbiter #(.OP_W(OP_W), .PROD_W(PROD_W), .ITER_MAX(OP_W)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .mplr0       (mplr0),
    .mplr1       (mplr1),
    .mcnd0       (mcnd0),
    .mcnd1       (mcnd1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .done0       (done0),
    .done1       (done1),
    .busy        (busy),
    .product_out (product_out),
    .sign_out    (sign_out),
    .dp          (dpi)
  );

  always #5 sys_clk = ~sys_clk;

  // Shift-add datapath emulation: multiplier magnitude shifts right,
  // multiplicand magnitude shifts left, product accumulates on reg_en.
  logic [OP_W-1:0]   dm = '0;
  logic [PROD_W-1:0] dc = '0, prod = '0;
  logic              sg = 1'b0;

  function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] v);
    return v[OP_W-1] ? (~v + 1'b1) : v;
  endfunction

  assign dpi.zflag          = (dm == '0);
  assign dpi.lsb_multiplier = dm[0];
  assign dpi.product        = prod;
  assign dpi.sign           = sg;

  always @(posedge sys_clk) begin
    if (dpi.load) begin
      dm <= mag(dpi.dp_multiplier);
      dc <= PROD_W'(mag(dpi.dp_multiplicand));
      sg <= dpi.dp_multiplier[OP_W-1] ^ dpi.dp_multiplicand[OP_W-1];
    end else if (dpi.shift_en) begin
      dm <= dm >> 1;
      dc <= dc << 1;
    end
    if (dpi.reg_en) prod <= (dpi.psel == PSEL_SUM) ? prod + dc : '0;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {gnt0, gnt1, done0, done1, busy,
                        dpi.load, dpi.reg_en, dpi.psel, dpi.shift_en}, 0);
    chk({tag, "_ops"}, {dpi.dp_multiplier, dpi.dp_multiplicand}, 0);
    chk({tag, "_res"}, {sign_out, product_out}, 0);
  endtask

  // Called at a falling edge while the DUT is idle with the request inputs
  // already set; the next rising edge is the grant decision edge.
  task automatic run_op(input bit scramble);
    int who, a, c, ma, mc, k, m, ep, es;
    bit seen_shift, seen_done;
    seen_shift = 0;
    seen_done  = 0;
    chk("idle_busy", busy, 0);
    if (req0 && req1) who = (mdl_last == 0) ? 1 : 0;
    else              who = req1 ? 1 : 0;
    if (who == 1) begin a = $signed(mplr1); c = $signed(mcnd1); end
    else          begin a = $signed(mplr0); c = $signed(mcnd0); end
    ma = (a < 0) ? -a : a;
    mc = (c < 0) ? -c : c;
    k = 0;
    m = ma;
    while (m != 0) begin k++; m = m >> 1; end
    ep = (ma * mc) % (1 << PROD_W);
    es = ((a < 0) != (c < 0)) ? 1 : 0;
    for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
      @(negedge sys_clk);
      if (cyc == 1) begin
        chk("grant", {gnt1, gnt0}, who ? 2 : 1);
        chk("busy", busy, 1);
        if (scramble) begin
          mplr0 = OP_W'($urandom);
          mcnd0 = OP_W'($urandom);
          mplr1 = OP_W'($urandom);
          mcnd1 = OP_W'($urandom);
          if (who == 1) req1 = 1'($urandom_range(0, 1));
          else          req0 = 1'($urandom_range(0, 1));
        end
      end
      if (dpi.shift_en) seen_shift = 1;
      if (done0 || done1) begin
        seen_done = 1;
        chk("done_cycle", cyc, 2 * k + 3);
        chk("done_who", {done1, done0}, who ? 2 : 1);
        chk("product", product_out, ep);
        chk("sign", sign_out, es);
      end
    end
    if (!seen_done) chk("done_timeout", 0, 1);
    if (k == 0) chk("no_shift", seen_shift, 0);
    mdl_last = who;
    @(negedge sys_clk);
    chk("hold_product", product_out, ep);
    chk("idle_gnt_done", {gnt1, gnt0, done1, done0}, 0);
  endtask

  initial begin
    bit hit;
    int r;
    repeat (3) @(negedge sys_clk);
    chk_zero("reset");
    rst = 1'b1;

    // Simultaneous requests, then both held: 0, 1, 0, 1
    req0 = 1; req1 = 1;
    mplr0 = 8'd2; mcnd0 = 8'd2; mplr1 = 8'd3; mcnd1 = 8'd3;
    repeat (4) run_op(0);

    // 5 x -3 on requester 0
    req1 = 0; req0 = 1; mplr0 = 8'd5; mcnd0 = 8'hFD;
    run_op(0);

    // Multiplier zero on requester 1
    req0 = 0; req1 = 1; mplr1 = 8'd0; mcnd1 = 8'd99;
    run_op(0);

    // Multiplier -128: iteration bound and zflag land together
    req1 = 0; req0 = 1; mplr0 = 8'h80; mcnd0 = 8'd127;
    run_op(0);

    // (-128) x (-128) wraps to magnitude 0, sign 0
    mplr0 = 8'h80; mcnd0 = 8'h80;
    run_op(0);

    // Operands change right after grant
    mplr0 = 8'd6; mcnd0 = 8'd7;
    run_op(1);

    // Random traffic with operands/requests disturbed after grant
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(1, 3);
      req0 = r[0];
      req1 = r[1];
      mplr0 = OP_W'($urandom); mcnd0 = OP_W'($urandom);
      mplr1 = OP_W'($urandom); mcnd1 = OP_W'($urandom);
      run_op(1);
    end

    // Reset in the middle of a 100 x 100 operation
    req0 = 1; req1 = 0; mplr0 = 8'd100; mcnd0 = 8'd100;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge sys_clk);
      if (dpi.shift_en) hit = 1;
    end
    chk("reach_shift", hit, 1);
    rst = 1'b0;
    @(negedge sys_clk);
    chk_zero("midop_reset");
    rst = 1'b1;
    mdl_last = 1;
    req0 = 0; req1 = 1; mplr1 = 8'hF9; mcnd1 = 8'd9;
    run_op(0);
    req1 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
